// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared core definitions: opcode field widths and the encodings used by the
// instruction-fetch / load-store memory arbiter.
package mem_arbiter_ctrl_pkg;

    localparam int ALU_OP_WIDTH = 4;
    localparam int LIS_OP_WIDTH = 3;
    localparam int BR_OP_WIDTH  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_ctrl.sv
// Two-requester (fetch, load/store) arbiter onto a single memory port with one
// outstanding transaction, alternating priority under contention and a response timeout.
module mem_arbiter_ctrl
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic                      if_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,

    input  logic                      ls_req_i,
    input  logic                      ls_we_i,
    input  logic [DATA_WIDTH/8-1:0]   ls_be_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
    output logic                      ls_gnt_o,
    output logic                      ls_rvalid_o,

    output logic [DATA_WIDTH-1:0]     rdata_o,

    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic                      stall_o,
    output logic                      err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e                state_reg;
    owner_e                    owner_reg;
    owner_e                    last_owner_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      err_reg;
    logic                      mem_req_reg;
    logic                      mem_we_reg;
    logic [DATA_WIDTH/8-1:0]   mem_be_reg;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0]     mem_wdata_reg;

    owner_e winner;
    logic   gnt_fire;
    logic   rsp_fire;
    logic   tmo_hit;

    // Under contention the previous owner yields, so neither side can starve.
    always_comb begin
        winner = OWN_IF;
        if (ls_req_i && !if_req_i) begin
            winner = OWN_LS;
        end else if (ls_req_i && if_req_i) begin
            winner = (last_owner_reg == OWN_LS) ? OWN_IF : OWN_LS;
        end
    end

    // Grant and response pulses are combinational so they land in the same
    // cycle as the memory handshake; reset masks them outright.
    always_comb begin
        gnt_fire = rstn_i && (state_reg == ST_REQ) && mem_gnt_i;
        tmo_hit  = (state_reg == ST_WAIT) && (cnt_reg == CNT_LAST) && !mem_rvalid_i;
        rsp_fire = rstn_i && (state_reg == ST_WAIT) && (mem_rvalid_i || (cnt_reg == CNT_LAST));
    end

    assign if_gnt_o    = gnt_fire && (owner_reg == OWN_IF);
    assign ls_gnt_o    = gnt_fire && (owner_reg == OWN_LS);
    assign if_rvalid_o = rsp_fire && (owner_reg == OWN_IF);
    assign ls_rvalid_o = rsp_fire && (owner_reg == OWN_LS);
    assign rdata_o     = tmo_hit ? '0 : mem_rdata_i;
    assign stall_o     = (if_req_i && !if_gnt_o) || (ls_req_i && !ls_gnt_o);

    assign err_o       = err_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_be_o    = mem_be_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_IF;
            last_owner_reg <= OWN_IF;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (if_req_i || ls_req_i) begin
                        owner_reg      <= winner;
                        last_owner_reg <= winner;
                        mem_req_reg    <= 1'b1;
                        state_reg      <= ST_REQ;
                        if (winner == OWN_LS) begin
                            mem_we_reg    <= ls_we_i;
                            mem_be_reg    <= ls_be_i;
                            mem_addr_reg  <= ls_addr_i;
                            mem_wdata_reg <= ls_wdata_i;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_be_reg    <= '1;
                            mem_addr_reg  <= if_addr_i;
                            mem_wdata_reg <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the last allowed cycle still counts as on time.
                    if (mem_rvalid_i) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
